vector_ldst_unit: RTL and testbench

- Memory-side execution stage for the CVP14 vector instructions VLD and VST; sits directly downstream of the instruction decoder.
- Decoder pulses a request carrying the base address (from the scalar register file), the destination vector register, and, for stores, the 256-bit source vector.
- Block sequences sixteen 16-bit element transfers on the processor memory bus (Addr/RD/WR/DataIn/dataOut).
- For loads, it assembles the 256-bit vector and issues a single write to the vector register file.

---
 rtl/cvp14_pkg.sv | 39 +++
 rtl/ldst_addr_gen.sv | 60 ++++++
 rtl/vector_ldst_unit.sv | 162 ++++++++++++++++
 tb/tb_vector_ldst_unit.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cvp14_pkg.sv
// ---------------------------------------------------------------------------
// cvp14_pkg
// Shared definitions for the CVP14 processor: instruction opcodes, vector
// geometry (element count/width), memory address width, vector register
// index width and the state encoding of the vector load/store unit.
// No ports; imported by the load/store unit and its address generator.
// ---------------------------------------------------------------------------
package cvp14_pkg;

    // Vector geometry and bus widths
    localparam int NUM_ELEM = 16;
    localparam int ELEM_W   = 16;
    localparam int ADDR_W   = 16;
    localparam int VREG_AW  = 3;
    localparam int VEC_W    = NUM_ELEM * ELEM_W;

    // Instruction opcodes
    localparam logic [3:0] OP_VADD = 4'b0000;
    localparam logic [3:0] OP_VDOT = 4'b0001;
    localparam logic [3:0] OP_SMUL = 4'b0010;
    localparam logic [3:0] OP_SST  = 4'b0011;
    localparam logic [3:0] OP_VLD  = 4'b0100;
    localparam logic [3:0] OP_VST  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SLH  = 4'b0111;
    localparam logic [3:0] OP_J    = 4'b1000;
    localparam logic [3:0] OP_NOP  = 4'b1111;

    // Vector load/store sequencer states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LD_ISSUE = 3'd1,
        LD_DRAIN = 3'd2,
        LD_WB    = 3'd3,
        ST_ISSUE = 3'd4,
        ST_DONE  = 3'd5
    } ldst_state_e;

endpackage

// File: rtl/ldst_addr_gen.sv
// ---------------------------------------------------------------------------
// ldst_addr_gen
// Element address generator for the vector load/store unit. Latches the
// element-0 base address when a request is accepted and steps through the
// sixteen element addresses (base+k, wrapping modulo 2^ADDR_W) while the
// parent is issuing. The address output is registered and returns to zero
// after the last element.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   load     in   request accepted this cycle: latch base_in
//   base_in  in   element-0 address
//   advance  in   an element is being issued this cycle
//   addr     out  registered address of the element currently issued
//   last     out  the element issued this cycle is the final one
// ---------------------------------------------------------------------------
module ldst_addr_gen
    import cvp14_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] base_in,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] base_q;
    logic [4:0]        cnt;
    logic [4:0]        cnt_inc;

    assign cnt_inc = cnt + 5'd1;
    assign last    = advance && (cnt == 5'(NUM_ELEM - 1));

    // The address register is preloaded with the base so element 0 appears
    // in the first issue cycle; later elements are base plus the incremented
    // count, letting the adder wrap naturally at the top of the address space.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            cnt    <= '0;
            addr   <= '0;
        end else if (load) begin
            base_q <= base_in;
            cnt    <= '0;
            addr   <= base_in;
        end else if (advance) begin
            if (last) begin
                cnt  <= '0;
                addr <= '0;
            end else begin
                cnt  <= cnt_inc;
                addr <= base_q + ADDR_W'(cnt_inc);
            end
        end
    end

endmodule

// File: rtl/vector_ldst_unit.sv
// ---------------------------------------------------------------------------
// vector_ldst_unit
// Memory-side execution stage for the CVP14 VLD/VST instructions. A request
// from the decoder is sequenced into sixteen 16-bit element transfers on the
// processor memory bus. Loads gather the returned elements into a 256-bit
// vector and write it to the vector register file in one cycle; stores
// stream the latched source vector out element by element. All outputs are
// driven from flops.
//
// Ports:
//   Clk1         in   clock, rising edge
//   Reset        in   asynchronous active-low reset (aborts any operation)
//   start        in   one-cycle request, ignored while busy
//   is_store     in   0 = VLD, 1 = VST (sampled with start)
//   base_addr    in   element-0 address (sampled with start)
//   vreg_dst     in   VLD destination register (sampled with start)
//   st_data      in   VST source vector (sampled with start)
//   busy         out  operation in progress
//   done         out  one-cycle completion pulse
//   Addr         out  memory address
//   RD           out  memory read strobe
//   WR           out  memory write strobe
//   dataOut      out  store data, valid while WR=1
//   DataIn       in   read data, valid the cycle after the RD cycle
//   vrf_wr_en    out  vector register file write enable
//   vrf_wr_dst   out  vector register file write destination
//   vrf_wr_data  out  assembled load vector
// ---------------------------------------------------------------------------
module vector_ldst_unit
    import cvp14_pkg::*;
(
    input  logic               Clk1,
    input  logic               Reset,
    input  logic               start,
    input  logic               is_store,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [VREG_AW-1:0] vreg_dst,
    input  logic [VEC_W-1:0]   st_data,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  Addr,
    output logic               RD,
    output logic               WR,
    output logic [ELEM_W-1:0]  dataOut,
    input  logic [ELEM_W-1:0]  DataIn,
    output logic               vrf_wr_en,
    output logic [VREG_AW-1:0] vrf_wr_dst,
    output logic [VEC_W-1:0]   vrf_wr_data
);

    ldst_state_e        state;
    ldst_state_e        next_state;
    logic               accept;
    logic               issuing;
    logic               last;
    logic [VREG_AW-1:0] dst_q;
    logic [VEC_W-1:0]   st_shift;
    logic               cap_pending;
    logic [3:0]         cap_cnt;
    logic [VEC_W-1:0]   elem_buf;

    assign accept      = (state == IDLE) && start;
    assign issuing     = (state == LD_ISSUE) || (state == ST_ISSUE);
    assign vrf_wr_data = elem_buf;

    ldst_addr_gen u_addr_gen (
        .clk     (Clk1),
        .rst_n   (Reset),
        .load    (accept),
        .base_in (base_addr),
        .advance (issuing),
        .addr    (Addr),
        .last    (last)
    );

    // State register
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so a request that
    // arrives while busy is dropped without touching the latched request.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = is_store ? ST_ISSUE : LD_ISSUE;
            LD_ISSUE: if (last) next_state = LD_DRAIN;
            LD_DRAIN: next_state = LD_WB;
            LD_WB:    next_state = IDLE;
            ST_ISSUE: if (last) next_state = ST_DONE;
            ST_DONE:  next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they line up
    // with the state they describe.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            busy       <= 1'b0;
            RD         <= 1'b0;
            WR         <= 1'b0;
            done       <= 1'b0;
            vrf_wr_en  <= 1'b0;
            vrf_wr_dst <= '0;
        end else begin
            busy       <= (next_state != IDLE);
            RD         <= (next_state == LD_ISSUE);
            WR         <= (next_state == ST_ISSUE);
            done       <= (next_state == LD_WB) || (next_state == ST_DONE);
            vrf_wr_en  <= (next_state == LD_WB);
            vrf_wr_dst <= (next_state == LD_WB) ? dst_q : '0;
        end
    end

    // Store data path: element 0 goes straight to dataOut on accept, the
    // rest of the vector is held in a shift register and peeled off one
    // element per issue cycle. dataOut is zero whenever WR is low.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            dataOut  <= '0;
            st_shift <= '0;
            dst_q    <= '0;
        end else begin
            if (accept && !is_store) begin
                dst_q <= vreg_dst;
            end
            if (accept && is_store) begin
                dataOut  <= st_data[ELEM_W-1:0];
                st_shift <= st_data >> ELEM_W;
            end else if ((state == ST_ISSUE) && !last) begin
                dataOut  <= st_shift[ELEM_W-1:0];
                st_shift <= st_shift >> ELEM_W;
            end else begin
                dataOut <= '0;
            end
        end
    end

    // Load capture: read data trails the RD cycle by one, so a delayed copy
    // of RD marks the cycles in which DataIn holds the next element.
    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            cap_pending <= 1'b0;
            cap_cnt     <= '0;
            elem_buf    <= '0;
        end else begin
            cap_pending <= RD;
            if (accept) begin
                cap_cnt <= '0;
            end else if (cap_pending) begin
                elem_buf[int'(cap_cnt) * ELEM_W +: ELEM_W] <= DataIn;
                cap_cnt <= cap_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_vector_ldst_unit.sv
// ---------------------------------------------------------------------------
// tb_vector_ldst_unit
// Self-checking bench for vector_ldst_unit. Each scenario fills a per-cycle
// input schedule, runs it, and compares a per-cycle snapshot of every output
// against a reference trace computed from the load/store timing rules.
// ---------------------------------------------------------------------------
module tb_vector_ldst_unit;
    import cvp14_pkg::*;

    localparam int MAXC = 160;

    typedef struct packed {
        logic               rd;
        logic               wr;
        logic               busy;
        logic               done;
        logic               vwe;
        logic [ADDR_W-1:0]  addr;
        logic [ELEM_W-1:0]  dout;
        logic [VREG_AW-1:0] vdst;
        logic [VEC_W-1:0]   vdata;
    } snap_t;

    logic               Clk1 = 1'b0;
    logic               Reset;
    logic               start;
    logic               is_store;
    logic [ADDR_W-1:0]  base_addr;
    logic [VREG_AW-1:0] vreg_dst;
    logic [VEC_W-1:0]   st_data;
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  Addr;
    logic               RD;
    logic               WR;
    logic [ELEM_W-1:0]  dataOut;
    logic [ELEM_W-1:0]  DataIn = '0;
    logic               vrf_wr_en;
    logic [VREG_AW-1:0] vrf_wr_dst;
    logic [VEC_W-1:0]   vrf_wr_data;

    int checks   = 0;
    int failures = 0;

    logic [ELEM_W-1:0]  mem [65536];
    logic               sch_start [MAXC];
    logic               sch_store [MAXC];
    logic [ADDR_W-1:0]  sch_base  [MAXC];
    logic [VREG_AW-1:0] sch_dst   [MAXC];
    logic [VEC_W-1:0]   sch_data  [MAXC];
    logic               sch_rst_n [MAXC];
    snap_t              tr    [MAXC];
    snap_t              post  [MAXC];
    snap_t              exp_s [MAXC];
    snap_t              msk   [MAXC];

    logic               rd_s   = 1'b0;
    logic [ADDR_W-1:0]  addr_s = '0;

    vector_ldst_unit dut (
        .Clk1        (Clk1),
        .Reset       (Reset),
        .start       (start),
        .is_store    (is_store),
        .base_addr   (base_addr),
        .vreg_dst    (vreg_dst),
        .st_data     (st_data),
        .busy        (busy),
        .done        (done),
        .Addr        (Addr),
        .RD          (RD),
        .WR          (WR),
        .dataOut     (dataOut),
        .DataIn      (DataIn),
        .vrf_wr_en   (vrf_wr_en),
        .vrf_wr_dst  (vrf_wr_dst),
        .vrf_wr_data (vrf_wr_data)
    );

    always #5 Clk1 = ~Clk1;

    // Memory model: a read seen in one cycle returns its data in the next;
    // any other cycle carries junk so mistimed captures show up.
    always @(negedge Clk1) begin
        rd_s   = RD;
        addr_s = Addr;
    end

    always @(posedge Clk1) begin
        #1;
        DataIn = rd_s ? mem[addr_s] : ELEM_W'($urandom);
    end

    function automatic snap_t sample();
        snap_t s;
        s.rd    = RD;
        s.wr    = WR;
        s.busy  = busy;
        s.done  = done;
        s.vwe   = vrf_wr_en;
        s.addr  = Addr;
        s.dout  = dataOut;
        s.vdst  = vrf_wr_dst;
        s.vdata = vrf_wr_data;
        return s;
    endfunction

    function automatic logic [VEC_W-1:0] rand_vec();
        logic [VEC_W-1:0] v;
        for (int i = 0; i < VEC_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Idle schedule: no start, reset released, junk on the request fields.
    task automatic clear_schedule();
        for (int c = 0; c < MAXC; c++) begin
            sch_start[c] = 1'b0;
            sch_store[c] = 1'($urandom);
            sch_base[c]  = ADDR_W'($urandom);
            sch_dst[c]   = VREG_AW'($urandom);
            sch_data[c]  = rand_vec();
            sch_rst_n[c] = 1'b1;
        end
    endtask

    task automatic schedule_op(input int c, input logic st, input logic [ADDR_W-1:0] base,
                               input logic [VREG_AW-1:0] dst, input logic [VEC_W-1:0] data);
        sch_start[c] = 1'b1;
        sch_store[c] = st;
        sch_base[c]  = base;
        sch_dst[c]   = dst;
        sch_data[c]  = data;
    endtask

    // Cycle c of the schedule is applied at the negedge inside cycle Tc,
    // after that cycle's outputs have been recorded in tr[c].
    task automatic run_cycles(input int n);
        for (int c = 0; c <= n; c++) begin
            @(negedge Clk1);
            tr[c]     = sample();
            start     = sch_start[c];
            is_store  = sch_store[c];
            base_addr = sch_base[c];
            vreg_dst  = sch_dst[c];
            st_data   = sch_data[c];
            Reset     = sch_rst_n[c];
            #1;
            post[c]   = sample();
        end
    endtask

    // Reference trace: an accepted load occupies T1..T18 (reads T1..T16,
    // writeback+done at T18); a store occupies T1..T17 (writes T1..T16,
    // done at T17). Requests are accepted only when idle and out of reset;
    // reset wipes everything after the cycle it is asserted in.
    task automatic build_expected(input int n);
        int free_at = 0;
        snap_t m;
        for (int c = 0; c < MAXC; c++) exp_s[c] = '0;
        for (int c = 0; c <= n; c++) begin
            if (!sch_rst_n[c]) begin
                for (int j = c + 1; j < MAXC; j++) exp_s[j] = '0;
                free_at = c + 1;
            end else if (sch_start[c] && c >= free_at) begin
                int len = sch_store[c] ? 17 : 18;
                logic [VEC_W-1:0] v;
                for (int j = c + 1; j <= c + len && j < MAXC; j++) exp_s[j].busy = 1'b1;
                for (int k = 0; k < NUM_ELEM; k++) begin
                    v[k*ELEM_W +: ELEM_W] = mem[ADDR_W'(sch_base[c] + ADDR_W'(k))];
                    if (c + 1 + k < MAXC) begin
                        exp_s[c+1+k].addr = ADDR_W'(sch_base[c] + ADDR_W'(k));
                        if (sch_store[c]) begin
                            exp_s[c+1+k].wr   = 1'b1;
                            exp_s[c+1+k].dout = sch_data[c][k*ELEM_W +: ELEM_W];
                        end else begin
                            exp_s[c+1+k].rd = 1'b1;
                        end
                    end
                end
                if (c + len < MAXC) begin
                    exp_s[c+len].done = 1'b1;
                    if (!sch_store[c]) begin
                        exp_s[c+len].vwe   = 1'b1;
                        exp_s[c+len].vdst  = sch_dst[c];
                        exp_s[c+len].vdata = v;
                    end
                end
                free_at = c + len + 1;
            end
        end
        for (int c = 0; c < MAXC; c++) begin
            m = '1;
            if (exp_s[c].busy && !exp_s[c].rd && !exp_s[c].wr) m.addr = '0;
            if (!exp_s[c].wr) m.dout = '0;
            if (!exp_s[c].vwe) begin
                m.vdst  = '0;
                m.vdata = '0;
            end
            msk[c] = m;
        end
    endtask

    task automatic test_reset();
        snap_t s;
        start     = 1'b0;
        is_store  = 1'b0;
        base_addr = '0;
        vreg_dst  = '0;
        st_data   = '0;
        Reset     = 1'b1;
        #2;
        Reset = 1'b0;
        #1;
        s = sample();
        checks++;
        if (s !== '0) begin
            failures++;
            $display("[TB] FAIL reset_async: got %h expected 0", s);
        end
        start = 1'b1;
        repeat (3) @(negedge Clk1);
        start = 1'b0;
        s = sample();
        checks++;
        if (s !== '0) begin
            failures++;
            $display("[TB] FAIL reset_held: got %h expected 0", s);
        end
        Reset = 1'b1;
        @(negedge Clk1);
        s = sample();
        checks++;
        if (s !== '0) begin
            failures++;
            $display("[TB] FAIL reset_release_idle: got %h expected 0", s);
        end
    endtask

    task automatic test_load_basic();
        for (int k = 0; k < NUM_ELEM; k++) mem[16'h0100 + k] = 16'(16'h1000 + k);
        clear_schedule();
        schedule_op(0, 1'b0, 16'h0100, 3'd3, rand_vec());
        run_cycles(22);
        build_expected(22);
        for (int c = 1; c <= 22; c++) begin
            checks++;
            if ((tr[c] & msk[c]) !== exp_s[c]) begin
                failures++;
                $display("[TB] FAIL load_basic T%0d: got %h expected %h", c, tr[c] & msk[c], exp_s[c]);
            end
        end
        for (int k = 0; k < NUM_ELEM; k++) begin
            checks++;
            if (tr[18].vdata[k*ELEM_W +: ELEM_W] !== 16'(16'h1000 + k)) begin
                failures++;
                $display("[TB] FAIL load_basic_elem%0d: got %h expected %h", k,
                         tr[18].vdata[k*ELEM_W +: ELEM_W], 16'(16'h1000 + k));
            end
        end
        checks++;
        if (tr[18].vdst !== 3'd3 || tr[19].busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_basic_wb: got dst=%0d busy19=%b expected dst=3 busy19=0", tr[18].vdst, tr[19].busy);
        end
    endtask

    task automatic test_store_basic();
        logic [VEC_W-1:0] d;
        for (int k = 0; k < NUM_ELEM; k++) d[k*ELEM_W +: ELEM_W] = 16'hA0A0 ^ 16'(k);
        clear_schedule();
        schedule_op(0, 1'b1, 16'h2000, 3'd5, d);
        run_cycles(20);
        build_expected(20);
        for (int c = 1; c <= 20; c++) begin
            checks++;
            if ((tr[c] & msk[c]) !== exp_s[c]) begin
                failures++;
                $display("[TB] FAIL store_basic T%0d: got %h expected %h", c, tr[c] & msk[c], exp_s[c]);
            end
        end
        for (int k = 0; k < NUM_ELEM; k++) begin
            checks++;
            if (tr[1+k].dout !== (16'hA0A0 ^ 16'(k)) || tr[1+k].addr !== 16'(16'h2000 + k)) begin
                failures++;
                $display("[TB] FAIL store_basic_elem%0d: got addr=%h data=%h expected addr=%h data=%h", k,
                         tr[1+k].addr, tr[1+k].dout, 16'(16'h2000 + k), 16'hA0A0 ^ 16'(k));
            end
        end
        checks++;
        if (tr[17].done !== 1'b1 || tr[17].vwe !== 1'b0) begin
            failures++;
            $display("[TB] FAIL store_basic_done: got done=%b vwe=%b expected done=1 vwe=0", tr[17].done, tr[17].vwe);
        end
    endtask

    task automatic test_load_wrap();
        clear_schedule();
        schedule_op(0, 1'b0, 16'hFFFE, VREG_AW'($urandom), rand_vec());
        run_cycles(22);
        build_expected(22);
        for (int c = 1; c <= 22; c++) begin
            checks++;
            if ((tr[c] & msk[c]) !== exp_s[c]) begin
                failures++;
                $display("[TB] FAIL load_wrap T%0d: got %h expected %h", c, tr[c] & msk[c], exp_s[c]);
            end
        end
        checks++;
        if (tr[1].addr !== 16'hFFFE || tr[2].addr !== 16'hFFFF || tr[3].addr !== 16'h0000 || tr[16].addr !== 16'h000D) begin
            failures++;
            $display("[TB] FAIL load_wrap_addr: got %h %h %h %h expected fffe ffff 0000 000d",
                     tr[1].addr, tr[2].addr, tr[3].addr, tr[16].addr);
        end
    endtask

    task automatic test_busy_start();
        clear_schedule();
        schedule_op(0, 1'b0, ADDR_W'($urandom), VREG_AW'($urandom), rand_vec());
        schedule_op(5, 1'b1, 16'h5555, VREG_AW'($urandom), rand_vec());
        run_cycles(24);
        build_expected(24);
        for (int c = 1; c <= 24; c++) begin
            checks++;
            if ((tr[c] & msk[c]) !== exp_s[c]) begin
                failures++;
                $display("[TB] FAIL busy_start T%0d: got %h expected %h", c, tr[c] & msk[c], exp_s[c]);
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_schedule();
        schedule_op(0, 1'b0, ADDR_W'($urandom), VREG_AW'($urandom), rand_vec());
        for (int c = 9; c <= 11; c++) sch_rst_n[c] = 1'b0;
        schedule_op(14, 1'b1, ADDR_W'($urandom), VREG_AW'($urandom), rand_vec());
        run_cycles(34);
        build_expected(34);
        checks++;
        if (post[9] !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_async: got %h expected 0", post[9]);
        end
        for (int c = 1; c <= 34; c++) begin
            checks++;
            if ((tr[c] & msk[c]) !== exp_s[c]) begin
                failures++;
                $display("[TB] FAIL reset_mid T%0d: got %h expected %h", c, tr[c] & msk[c], exp_s[c]);
            end
        end
        checks++;
        if (tr[31].done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_mid_store_done: got %b expected 1", tr[31].done);
        end
    endtask

    task automatic test_back_to_back();
        clear_schedule();
        schedule_op(0, 1'b1, ADDR_W'($urandom), VREG_AW'($urandom), rand_vec());
        schedule_op(18, 1'b0, ADDR_W'($urandom), VREG_AW'($urandom), rand_vec());
        run_cycles(40);
        build_expected(40);
        for (int c = 1; c <= 40; c++) begin
            checks++;
            if ((tr[c] & msk[c]) !== exp_s[c]) begin
                failures++;
                $display("[TB] FAIL back_to_back T%0d: got %h expected %h", c, tr[c] & msk[c], exp_s[c]);
            end
        end
        checks++;
        if (tr[18].rd !== 1'b0 || tr[19].rd !== 1'b1) begin
            failures++;
            $display("[TB] FAIL back_to_back_rd: got rd18=%b rd19=%b expected 0 1", tr[18].rd, tr[19].rd);
        end
    endtask

    task automatic test_random();
        int r;
        clear_schedule();
        for (int c = 0; c <= 120; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                schedule_op(c, 1'($urandom), ADDR_W'($urandom), VREG_AW'($urandom), rand_vec());
            end
        end
        r = int'($urandom_range(30, 100));
        for (int c = r; c < r + int'($urandom_range(1, 3)); c++) sch_rst_n[c] = 1'b0;
        run_cycles(150);
        build_expected(150);
        for (int c = 1; c <= 150; c++) begin
            checks++;
            if ((tr[c] & msk[c]) !== exp_s[c] || (tr[c].rd && tr[c].wr)) begin
                failures++;
                $display("[TB] FAIL random T%0d: got %h expected %h", c, tr[c] & msk[c], exp_s[c]);
            end
        end
    endtask

    initial begin
        $display("[TB] vector_ldst_unit bench starting");
        for (int a = 0; a < 65536; a++) mem[a] = ELEM_W'($urandom);
        test_reset();
        test_load_basic();
        test_store_basic();
        test_load_wrap();
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
